// File: rtl/iter_alu_pkg.sv
// Shared definitions for iter_alu: operation codes and the controller state type.
package iter_alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;
   localparam logic [3:0] OP_MULH = 4'b1101;
   localparam logic [3:0] OP_DIV  = 4'b1110;
   localparam logic [3:0] OP_REM  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/iter_muldiv_core.sv
// Iterative magnitude multiplier (shift-add) and, with ITER_ALU_DIV_EN, restoring divider
// with final sign correction. One iteration per cycle for WIDTH cycles after start.
module iter_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef ITER_ALU_DIV_EN
   input  logic             is_div,
`endif
   input  logic             is_high,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + WIDTH'(1'b1)) : v;
   endfunction

   // acc_r holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide
   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   mag_r;
   logic [CW-1:0]      cnt_r;
   logic               active_r;
   logic               neg_r;
   logic               high_r;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] step_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   load_mag_s;
   logic [WIDTH-1:0]   load_lo_s;
   logic               load_neg_s;
`ifdef ITER_ALU_DIV_EN
   logic               div_r;
   logic [WIDTH:0]     shifted_s;
   logic [WIDTH:0]     diff_s;
   logic               ge_s;
   logic [WIDTH-1:0]   pick_s;
`endif

   assign done = active_r && (cnt_r == CW'(WIDTH-1));

   // Operand magnitudes and result sign captured at start
   always_comb begin
`ifdef ITER_ALU_DIV_EN
      load_mag_s = is_div ? magnitude(b) : magnitude(a);
      load_lo_s  = is_div ? magnitude(a) : magnitude(b);
      load_neg_s = (is_div && is_high) ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
`else
      load_mag_s = magnitude(a);
      load_lo_s  = magnitude(b);
      load_neg_s = a[WIDTH-1] ^ b[WIDTH-1];
`endif
   end

   // One iteration step plus the sign-corrected result of that step
   always_comb begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
      step_s    = {mul_sum_s, acc_r[WIDTH-1:1]};
      prod_s    = neg_r ? (~step_s + (2*WIDTH)'(1'b1)) : step_s;
      result    = high_r ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
`ifdef ITER_ALU_DIV_EN
      shifted_s = acc_r[2*WIDTH-1:WIDTH-1];
      diff_s    = shifted_s - {1'b0, mag_r};
      // a set top bit already exceeds any divisor magnitude; otherwise no borrow means fits
      ge_s      = shifted_s[WIDTH] | ~diff_s[WIDTH];
      pick_s    = {WIDTH{1'b0}};
      if (div_r) begin
         step_s = {(ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0]), acc_r[WIDTH-2:0], ge_s};
         pick_s = high_r ? step_s[2*WIDTH-1:WIDTH] : step_s[WIDTH-1:0];
         result = neg_r ? (~pick_s + WIDTH'(1'b1)) : pick_s;
      end else begin
         pick_s = {WIDTH{1'b0}};
      end
`endif
   end

   // Iteration state: load on start, step while active, stop after the last step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r    <= {(2*WIDTH){1'b0}};
         mag_r    <= {WIDTH{1'b0}};
         cnt_r    <= {CW{1'b0}};
         active_r <= 1'b0;
         neg_r    <= 1'b0;
         high_r   <= 1'b0;
`ifdef ITER_ALU_DIV_EN
         div_r    <= 1'b0;
`endif
      end else if (start) begin
         acc_r    <= {{WIDTH{1'b0}}, load_lo_s};
         mag_r    <= load_mag_s;
         cnt_r    <= {CW{1'b0}};
         active_r <= 1'b1;
         neg_r    <= load_neg_s;
         high_r   <= is_high;
`ifdef ITER_ALU_DIV_EN
         div_r    <= is_div;
`endif
      end else if (active_r) begin
         acc_r <= step_s;
         cnt_r <= cnt_r + CW'(1'b1);
         if (done) begin
            active_r <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle logic/shift/add ops, iterative MUL/MULH and DIV/REM.
// Divider is present only when ITER_ALU_DIV_EN is defined.
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   state_t           state_r, next_s;
   logic [WIDTH-1:0] data_r;
   logic             zero_r;
   logic [WIDTH:0]   sub_s;
   logic [SHW-1:0]   sh_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH-1:0] load_data_s;
   logic             load_s;
   logic             start_s;
   logic             is_mul_s;
   logic             is_div_s;
   logic             core_done_s;
   logic [WIDTH-1:0] core_result_s;

   assign is_mul_s = (op_i == OP_MUL) || (op_i == OP_MULH);
   assign is_div_s = (op_i == OP_DIV) || (op_i == OP_REM);

   // Single-cycle operations; the sign-extended subtractor also yields an overflow-safe SLT
   always_comb begin
      sub_s = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};
      sh_s  = b_i[SHW-1:0];
      case (op_i)
         OP_ADD:  alu_res_s = a_i + b_i;
         OP_SUB:  alu_res_s = sub_s[WIDTH-1:0];
         OP_AND:  alu_res_s = a_i & b_i;
         OP_OR:   alu_res_s = a_i | b_i;
         OP_XOR:  alu_res_s = a_i ^ b_i;
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, sub_s[WIDTH]};
         OP_SLL:  alu_res_s = a_i << sh_s;
         OP_SRL:  alu_res_s = a_i >> sh_s;
         OP_SRA:  alu_res_s = $unsigned($signed(a_i) >>> sh_s);
         default: alu_res_s = a_i + b_i;
      endcase
   end

   iter_muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   (start_s),
`ifdef ITER_ALU_DIV_EN
      .is_div  (is_div_s),
`endif
      .is_high (op_i[0]),
      .a       (a_i),
      .b       (b_i),
      .done    (core_done_s),
      .result  (core_result_s)
   );

   // Next state, core launch and result load
   always_comb begin
      next_s      = state_r;
      start_s     = 1'b0;
      load_s      = 1'b0;
      load_data_s = alu_res_s;
      case (state_r)
         IDLE: begin
            if (in_valid_i) begin
               if (is_mul_s) begin
                  next_s  = BUSY;
                  start_s = 1'b1;
`ifdef ITER_ALU_DIV_EN
               end else if (is_div_s && (b_i == {WIDTH{1'b0}})) begin
                  next_s      = DONE;
                  load_s      = 1'b1;
                  load_data_s = op_i[0] ? a_i : {WIDTH{1'b1}};
               end else if (is_div_s) begin
                  next_s  = BUSY;
                  start_s = 1'b1;
`else
               end else if (is_div_s) begin
                  next_s      = DONE;
                  load_s      = 1'b1;
                  load_data_s = {WIDTH{1'b1}};
`endif
               end else begin
                  next_s = DONE;
                  load_s = 1'b1;
               end
            end else begin
               next_s = IDLE;
            end
         end
         BUSY: begin
            if (core_done_s) begin
               next_s      = DONE;
               load_s      = 1'b1;
               load_data_s = core_result_s;
            end else begin
               next_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               next_s = IDLE;
            end else begin
               next_s = DONE;
            end
         end
         default: next_s = IDLE;
      endcase
   end

   // State and registered result/zero flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         data_r  <= {WIDTH{1'b0}};
         zero_r  <= 1'b1;
      end else begin
         state_r <= next_s;
         if (load_s) begin
            data_r <= load_data_s;
            zero_r <= (load_data_s == {WIDTH{1'b0}});
         end
      end
   end

   assign in_ready_o  = (state_r == IDLE);
   assign out_valid_o = (state_r == DONE);
   assign data_o      = data_r;
   assign zero_o      = zero_r;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (8..64, even).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from operand b.
REQ-003 SHALL have port clk_i input 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid_i input 1: request present.
REQ-006 SHALL have port in_ready_o output 1: block can accept request.
REQ-007 SHALL have port op_i input 4: operation code.
REQ-008 SHALL have port a_i input WIDTH: operand a, signed.
REQ-009 SHALL have port b_i input WIDTH: operand b, signed.
REQ-010 SHALL have port out_valid_o output 1: result present.
REQ-011 SHALL have port out_ready_i input 1: consumer accepts result.
REQ-012 SHALL have port data_o output WIDTH: result.
REQ-013 SHALL have port zero_o output 1: data_o equals 0.

Function
REQ-014 SHALL decode op_i: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLT 1000, SLL 1001, SRL 1010, SRA 1011, MUL 1100 (low WIDTH bits), MULH 1101 (signed high WIDTH bits), DIV 1110 (signed quotient), REM 1111 (signed remainder); other codes behave as ADD.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready_o = (state == IDLE).
REQ-016 SHALL accept a request on in_valid_i & in_ready_o, capturing op, a, b.
REQ-017 SHALL, for non-MUL/DIV ops, go IDLE->DONE with result registered (latency 1 cycle from acceptance).
REQ-018 SHALL compute SLT as signed a<b using WIDTH+1-bit subtraction, result 1 or 0, correct under overflow.
REQ-019 SHALL use b[SHW-1:0] as shift amount; SRA sign-fills.
REQ-020 SHALL, for MUL/MULH, go IDLE->BUSY, run radix-2 shift-add on magnitudes for exactly WIDTH cycles, apply sign, then DONE; out_valid_o asserts WIDTH+1 cycles after acceptance.
REQ-021 SHALL, for DIV/REM, run restoring division on magnitudes for WIDTH cycles; quotient sign = sign(a)^sign(b), remainder sign = sign(a); same latency as MUL.
REQ-022 SHALL, on divide-by-zero, skip BUSY: quotient all ones, remainder = a, latency 1.
REQ-023 SHALL, on most-negative / -1, produce quotient = most-negative and remainder = 0 at normal latency.
REQ-024 SHALL hold data_o and zero_o stable in DONE until out_valid_o & out_ready_i, then return to IDLE; no new request accepted in the same cycle.
REQ-025 SHALL drive out_valid_o = (state == DONE); zero_o registered together with data_o.
REQ-026 SHALL ignore in_valid_i, op_i, a_i and b_i while BUSY or DONE.

Reset
REQ-027 SHALL, on rst_i assertion (including mid-BUSY), abort the operation and enter IDLE immediately; data_o = 0, zero_o = 1, out_valid_o = 0, in_ready_o = 1 after reset.
REQ-028 SHALL clear iteration counter and partial registers on reset.

Configuration
REQ-029 SHALL use macro ITER_ALU_DIV_EN: when defined, DIV/REM are implemented per REQ-021..023; when undefined, no divider logic exists and DIV/REM complete in 1 cycle with data_o all ones and zero_o 0.

Structure
REQ-030 SHALL place op-code constants and the FSM state type in package iter_alu_pkg.
REQ-031 SHALL implement iteration datapath (counter, shift-add, restoring-subtract, sign fix) in sub-module iter_muldiv_core; single-cycle ops remain in iter_alu.

Verification (WIDTH=32)
REQ-032 SHALL check SUB a=5, b=7 -> data_o=0xFFFFFFFE, zero_o=0, out_valid 1 cycle after accept; SLT a=0x80000000, b=1 -> 1.
REQ-033 SHALL check MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0; MUL a=-3, b=7 -> 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-034 SHALL check DIV a=-7, b=2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIV a=9, b=0 -> 0xFFFFFFFF latency 1; DIV 0x80000000 / -1 -> 0x80000000.
REQ-035 SHALL check back-pressure: out_ready_i low 10 cycles -> data_o stable, in_ready_o low, second in_valid_i ignored.
REQ-036 SHALL check rst_i pulse at BUSY cycle 10 -> IDLE next, out_valid_o 0, next ADD 1+1 -> 2.
REQ-037 SHALL check build without ITER_ALU_DIV_EN: DIV 9/3 -> 0xFFFFFFFF, latency 1.
